// File: rtl/if_fetch_stage_pkg.sv
// Fetch-stage shared types and constants.
// Imported by the fetch stage, its slot ring and its interface.
package if_fetch_stage_pkg;

  localparam int WORD_W = 32;
  localparam int INST_BYTES = 4;
  localparam int DROP_W = 8;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_VECTOR = 32'h0;
  localparam word_t PC_INC = WORD_W'(INST_BYTES);

  typedef struct packed {
    word_t pc;
    word_t data;
    logic  filled;
  } slot_t;

  function automatic word_t align_pc(word_t pc);
    return {pc[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: imem request/response, redirect and decode
// handshake bundled for the stage and its environment.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic  imem_req_valid;
  logic  imem_req_ready;
  word_t imem_addr;
  logic  imem_resp_valid;
  word_t imem_resp_data;
  logic  redirect_valid;
  word_t redirect_pc;
  logic  inst_valid;
  logic  inst_ready;
  word_t inst_data;
  word_t inst_pc;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/if_fetch_stage_slot_buf.sv
// DEPTH-entry fetch ring: slots are allocated at request,
// filled by responses in order, popped by decode, flushed on redirect.
module if_fetch_stage_slot_buf
  import if_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  input  logic alloc,
  input  word_t alloc_pc,
  input  logic fill,
  input  word_t fill_data,
  input  logic pop,
  output logic head_valid,
  output word_t head_pc,
  output word_t head_data,
  output logic full,
  output logic [$clog2(DEPTH):0] pend
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  slot_t slots [DEPTH];
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] head_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      pend      <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      pend      <= '0;
    end else begin
      if (alloc) begin
        slots[alloc_ptr].pc     <= alloc_pc;
        slots[alloc_ptr].filled <= 1'b0;
        alloc_ptr <= alloc_ptr + 1'b1;
      end
      if (fill) begin
        slots[fill_ptr].data   <= fill_data;
        slots[fill_ptr].filled <= 1'b1;
        fill_ptr <= fill_ptr + 1'b1;
      end
      if (pop) head_ptr <= head_ptr + 1'b1;
      count <= count + CW'(alloc) - CW'(pop);
      pend  <= pend + CW'(alloc) - CW'(fill);
    end
  end

  assign full = (count == CW'(DEPTH));
  assign head_valid = (count != '0) && slots[head_ptr].filled;
  // zero when invalid so decode never sees a stale word
  assign head_pc   = head_valid ? slots[head_ptr].pc : '0;
  assign head_data = head_valid ? slots[head_ptr].data : '0;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns fetch PC, issues imem reads,
// drops stale responses after a redirect, feeds decode.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter word_t RESET_PC = RESET_VECTOR
) (
  input logic clk,
  input logic reset_n,
  if_fetch_stage_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  word_t fetch_pc;
  logic [DROP_W-1:0] drop_cnt;
  logic run;

  logic full;
  logic accept;
  logic drop;
  logic fill;
  logic pop;
  logic head_valid;
  logic [CW-1:0] pend;
  word_t head_pc;
  word_t head_data;

  assign bus.imem_req_valid = run && !full && !bus.redirect_valid;
  assign bus.imem_addr = fetch_pc;

  assign accept = bus.imem_req_valid && bus.imem_req_ready;
  assign drop = bus.imem_resp_valid && (drop_cnt != '0);
  assign fill = bus.imem_resp_valid && (drop_cnt == '0);
  assign pop = head_valid && bus.inst_ready;

  assign bus.inst_valid = head_valid;
  assign bus.inst_pc = head_pc;
  assign bus.inst_data = head_data;

  if_fetch_stage_slot_buf #(.DEPTH(DEPTH)) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (bus.redirect_valid),
    .alloc      (accept),
    .alloc_pc   (fetch_pc),
    .fill       (fill),
    .fill_data  (bus.imem_resp_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_data  (head_data),
    .full       (full),
    .pend       (pend)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= align_pc(RESET_PC);
      drop_cnt <= '0;
      run      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (bus.redirect_valid) begin
        fetch_pc <= align_pc(bus.redirect_pc);
        // in-flight words still owed, minus the one arriving now
        drop_cnt <= drop_cnt + DROP_W'(pend)
                    - DROP_W'(bus.imem_resp_valid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_INC;
        if (drop) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  a_resp_legal: assert property (
    @(posedge clk) disable iff (!reset_n)
    bus.imem_resp_valid |-> (drop_cnt != '0 || pend != '0)
  );

endmodule
